// File: rtl/payment_if.sv
// Checkout handshake bundle: order offer, coin insertion, and payout/status back to the environment.
interface payment_if;
  logic       order_valid;
  logic [7:0] order_total;
  logic       order_ready;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic       cancel;
  logic [7:0] due_amount;
  logic [8:0] paid_amount;
  logic       coin_reject;
  logic       change_valid;
  logic [1:0] change_code;
  logic       refund;
  logic       done;

  modport master (
    output order_valid, order_total, coin_valid, coin_code, cancel,
    input  order_ready, due_amount, paid_amount, coin_reject,
           change_valid, change_code, refund, done
  );

  modport slave (
    input  order_valid, order_total, coin_valid, coin_code, cancel,
    output order_ready, due_amount, paid_amount, coin_reject,
           change_valid, change_code, refund, done
  );
endinterface

// File: rtl/payment_terminal.sv
// Checkout terminal: accepts an order total, collects coins, then pays out change greedily.
//  state  | meaning
//  IDLE   | waiting for an order, order_ready high
//  PAY    | accumulating coins until total covered or cancel
//  CHANGE | dispensing one change/refund coin per cycle
//  DONE   | one-cycle done pulse, then back to IDLE
module payment_terminal #(
  parameter logic [7:0] COIN_A = 8'd1,
  parameter logic [7:0] COIN_B = 8'd5,
  parameter logic [7:0] COIN_C = 8'd10,
  parameter logic [7:0] COIN_D = 8'd50
) (
  input logic       clk,
  input logic       reset_n,
  payment_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PAY, CHANGE, DONE} state_t;

  state_t     state;
  logic [7:0] due_amount;
  logic [8:0] paid_amount;
  logic [8:0] change_rem;
  logic       order_ready;
  logic       coin_reject;
  logic       change_valid;
  logic [1:0] change_code;
  logic       refund;
  logic       done;

  logic [8:0] paid_next;
  logic       pay_finish;
  logic [8:0] disp_src;
  logic [1:0] disp_code;
  logic [8:0] disp_val;

  function automatic logic [8:0] coin_value(input logic [1:0] code);
    case (code)
      2'b00:   coin_value = {1'b0, COIN_A};
      2'b01:   coin_value = {1'b0, COIN_B};
      2'b10:   coin_value = {1'b0, COIN_C};
      default: coin_value = {1'b0, COIN_D};
    endcase
  endfunction

  function automatic logic [1:0] pick_code(input logic [8:0] amt);
    if (amt >= {1'b0, COIN_D})      pick_code = 2'b11;
    else if (amt >= {1'b0, COIN_C}) pick_code = 2'b10;
    else if (amt >= {1'b0, COIN_B}) pick_code = 2'b01;
    else                            pick_code = 2'b00;
  endfunction

  // The first change coin is chosen on the PAY->CHANGE edge so it appears one cycle after
  // the covering coin; change_rem then holds what is still owed after the visible coin.
  always_comb begin
    paid_next  = paid_amount + (bus.coin_valid ? coin_value(bus.coin_code) : 9'd0);
    pay_finish = bus.cancel || (paid_next >= {1'b0, due_amount});
    if (state == PAY)
      disp_src = bus.cancel ? paid_next : (paid_next - {1'b0, due_amount});
    else
      disp_src = change_rem;
    disp_code = pick_code(disp_src);
    disp_val  = coin_value(disp_code);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      due_amount   <= 8'd0;
      paid_amount  <= 9'd0;
      change_rem   <= 9'd0;
      order_ready  <= 1'b1;
      coin_reject  <= 1'b0;
      change_valid <= 1'b0;
      change_code  <= 2'b00;
      refund       <= 1'b0;
      done         <= 1'b0;
    end else begin
      coin_reject  <= bus.coin_valid && (state != PAY);
      done         <= 1'b0;
      change_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.order_valid) begin
            due_amount  <= bus.order_total;
            paid_amount <= 9'd0;
            refund      <= 1'b0;
            order_ready <= 1'b0;
            if (bus.order_total == 8'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= PAY;
            end
          end
        end
        PAY: begin
          paid_amount <= paid_next;
          if (pay_finish) begin
            state  <= CHANGE;
            refund <= bus.cancel;
            if (disp_src != 9'd0) begin
              change_valid <= 1'b1;
              change_code  <= disp_code;
              change_rem   <= disp_src - disp_val;
            end else begin
              change_code  <= 2'b00;
              change_rem   <= 9'd0;
            end
          end
        end
        CHANGE: begin
          if (change_rem != 9'd0) begin
            change_valid <= 1'b1;
            change_code  <= disp_code;
            change_rem   <= change_rem - disp_val;
          end else begin
            change_code <= 2'b00;
            state       <= DONE;
            done        <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          refund      <= 1'b0;
          order_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.order_ready  = order_ready;
  assign bus.due_amount   = due_amount;
  assign bus.paid_amount  = paid_amount;
  assign bus.coin_reject  = coin_reject;
  assign bus.change_valid = change_valid;
  assign bus.change_code  = change_code;
  assign bus.refund       = refund;
  assign bus.done         = done;

endmodule

// File: tb/tb_payment_terminal.sv
// Bench for payment_terminal: directed checkout scenarios plus random orders against an arithmetic model.
module tb_payment_terminal;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  payment_if bus();
  payment_terminal dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int compares = 0;
  int fails    = 0;
  int cq[$];
  int cancel_at;
  int exp_change[$];

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int coin_val(input int code);
    case (code)
      0:       return 1;
      1:       return 5;
      2:       return 10;
      default: return 50;
    endcase
  endfunction

  // Greedy payout: repeatedly hand out the largest coin not exceeding what is owed.
  task automatic build_change(input int amt);
    exp_change.delete();
    while (amt > 0) begin
      for (int c = 3; c >= 0; c--) begin
        if (coin_val(c) <= amt) begin
          exp_change.push_back(c);
          amt -= coin_val(c);
          break;
        end
      end
    end
  endtask

  task automatic clear_inputs;
    bus.order_valid = 1'b0;
    bus.order_total = 8'd0;
    bus.coin_valid  = 1'b0;
    bus.coin_code   = 2'b00;
    bus.cancel      = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"},  bus.order_ready,  1);
    chk({tag, "_due"},    bus.due_amount,   0);
    chk({tag, "_paid"},   bus.paid_amount,  0);
    chk({tag, "_rej"},    bus.coin_reject,  0);
    chk({tag, "_cv"},     bus.change_valid, 0);
    chk({tag, "_code"},   bus.change_code,  0);
    chk({tag, "_refund"}, bus.refund,       0);
    chk({tag, "_done"},   bus.done,         0);
  endtask

  task automatic run_txn(input int total, input int reset_at);
    int  paid = 0;
    int  idx = 0;
    int  n;
    int  code;
    bit  ended = 0;
    bit  refunding = 0;
    bit  rej = 0;
    chk("idle_ready", bus.order_ready, 1);
    bus.order_valid = 1'b1;
    bus.order_total = total[7:0];
    step;
    bus.order_valid = 1'b0;
    chk("accept_ready", bus.order_ready, 0);
    chk("due_latch", bus.due_amount, total);
    chk("paid_clear", bus.paid_amount, 0);
    if (total == 0) begin
      chk("zero_done", bus.done, 1);
      chk("zero_cv", bus.change_valid, 0);
      chk("zero_refund", bus.refund, 0);
    end else begin
      while (!ended && idx < cq.size()) begin
        code = cq[idx];
        bus.coin_valid  = (code >= 0);
        bus.coin_code   = (code >= 0) ? code[1:0] : 2'b00;
        bus.cancel      = (idx == cancel_at);
        bus.order_valid = ($urandom_range(0, 3) == 0);
        bus.order_total = 8'($urandom);
        if (code >= 0) paid += coin_val(code);
        step;
        clear_inputs();
        chk("paid_run", bus.paid_amount, paid);
        chk("due_hold", bus.due_amount, total);
        chk("pay_no_rej", bus.coin_reject, 0);
        chk("pay_no_done", bus.done, 0);
        if (idx == cancel_at) begin
          ended = 1;
          refunding = 1;
          build_change(paid);
        end else if (paid >= total) begin
          ended = 1;
          build_change(paid - total);
        end
        idx++;
      end
      chk("covered", ended, 1);
      n = exp_change.size();
      for (int i = 0; i < ((n == 0) ? 1 : n); i++) begin
        chk("chg_valid", bus.change_valid, (n > 0) ? 1 : 0);
        if (n > 0) chk("chg_code", bus.change_code, exp_change[i]);
        chk("chg_refund", bus.refund, refunding);
        chk("chg_rej", bus.coin_reject, rej);
        chk("chg_paid_hold", bus.paid_amount, paid);
        chk("chg_no_done", bus.done, 0);
        if (i == reset_at) begin
          #2 reset_n = 1'b0;
          #1 chk_reset_state("async_rst");
          @(negedge clk) reset_n = 1'b1;
          step;
          chk_reset_state("post_rst");
          return;
        end
        rej = ($urandom_range(0, 2) == 0);
        bus.coin_valid = rej;
        bus.coin_code  = 2'($urandom);
        step;
        bus.coin_valid = 1'b0;
      end
      chk("done_pulse", bus.done, 1);
      chk("done_cv", bus.change_valid, 0);
      chk("done_refund", bus.refund, refunding);
      chk("done_rej", bus.coin_reject, rej);
      chk("done_paid", bus.paid_amount, paid);
    end
    step;
    chk("end_done_low", bus.done, 0);
    chk("end_ready", bus.order_ready, 1);
    chk("end_refund", bus.refund, 0);
    chk("end_due_hold", bus.due_amount, total);
    chk("end_paid_hold", bus.paid_amount, paid);
  endtask

  task automatic gen_random(input int total);
    int s = 0;
    int c;
    cq.delete();
    while (s < total) begin
      if ($urandom_range(0, 4) == 0) begin
        cq.push_back(-1);
      end else begin
        c = $urandom_range(0, 3);
        cq.push_back(c);
        s += coin_val(c);
      end
    end
    cancel_at = ($urandom_range(0, 3) == 0 && cq.size() > 0) ? $urandom_range(0, cq.size() - 1) : -1;
  endtask

  initial begin
    int total;
    clear_inputs();
    reset_n = 1'b0;
    #12;
    chk_reset_state("reset");
    @(negedge clk) reset_n = 1'b1;
    step;
    chk_reset_state("after_reset");

    // coin while idle is bounced and never counted
    bus.coin_valid = 1'b1;
    bus.coin_code  = 2'b11;
    step;
    bus.coin_valid = 1'b0;
    chk("idle_rej", bus.coin_reject, 1);
    chk("idle_rej_paid", bus.paid_amount, 0);
    step;
    chk("idle_rej_clear", bus.coin_reject, 0);

    cq = '{3, 3};        cancel_at = -1; run_txn(85, -1);
    cq = '{2, 2, 2};     cancel_at = -1; run_txn(30, -1);
    cq = '{1, 0, -1};    cancel_at = 2;  run_txn(70, -1);
    cq.delete();         cancel_at = -1; run_txn(0, -1);
    cq = '{2};           cancel_at = 0;  run_txn(40, -1);
    cq = '{-1};          cancel_at = 0;  run_txn(20, -1);
    cq = '{3, 3, 3, 3, 3, 3}; cancel_at = -1; run_txn(255, -1);
    cq = '{3};           cancel_at = -1; run_txn(1, 3);
    cq = '{2, 1};        cancel_at = -1; run_txn(12, -1);

    for (int t = 0; t < 40; t++) begin
      total = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      gen_random(total);
      run_txn(total, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
